// File: rtl/calc_pkg.sv
// Shared calculator datapath types and constants.
// The corrected-result struct is width-generic, so it is provided as a macro taking WIDTH.
`ifndef CALC_PKG_SV
`define CALC_PKG_SV

`define CALC_CORR_RES_T(W) struct packed { logic sign; logic [(W):0] magnitude; logic is_zero; }

package calc_pkg;
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;
endpackage

`endif

// File: rtl/result_corrector_if.sv
// Valid/ready handshake bundle between the adder/subtractor, the corrector and the display stage.
interface result_corrector_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic             eff_sub;
    logic             a_lt_b;
    logic             carry;
    logic             sign_a;
    logic [WIDTH-1:0] sum;
    logic             out_valid;
    logic             out_ready;
    logic             sign;
    logic [WIDTH:0]   magnitude;
    logic             is_zero;

    modport master (
        output in_valid, eff_sub, a_lt_b, carry, sign_a, sum, out_ready,
        input  in_ready, out_valid, sign, magnitude, is_zero
    );

    modport slave (
        input  in_valid, eff_sub, a_lt_b, carry, sign_a, sum, out_ready,
        output in_ready, out_valid, sign, magnitude, is_zero
    );
endinterface

// File: rtl/result_corrector_twos_negate.sv
// Combinational two's-complement negation of a WIDTH-bit value; the carry out is discarded.
module twos_negate #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y
);
    assign y = ~x + WIDTH'(1);
endmodule

// File: rtl/result_corrector.sv
// Two-stage sign-magnitude correction of raw adder/subtractor results with valid/ready
// handshakes and a saturating count of delivered carry-out results.
module result_corrector
    import calc_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    result_corrector_if.slave bus,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] ovf_count
);
    typedef `CALC_CORR_RES_T(WIDTH) corr_res_t;

    logic             s1_valid;
    logic             s1_eff_sub;
    logic             s1_a_lt_b;
    logic             s1_carry;
    logic             s1_sign_a;
    logic [WIDTH-1:0] s1_sum;
    logic             s2_valid;
    corr_res_t        s2_res;
    corr_res_t        corr;
    logic [WIDTH-1:0] neg_sum;
    logic             s2_load;
    logic             in_xfer;
    logic             out_xfer;

    twos_negate #(.WIDTH(WIDTH)) u_negate (
        .x (s1_sum),
        .y (neg_sum)
    );

    // in_ready looks through s2 so a draining pipe accepts every cycle.
    assign s2_load      = s1_valid && (!s2_valid || bus.out_ready);
    assign bus.in_ready = !s1_valid || s2_load;
    assign in_xfer      = bus.in_valid && bus.in_ready;
    assign out_xfer     = s2_valid && bus.out_ready;

    always_comb begin
        corr = '0;
        if (s1_eff_sub == OP_ADD) begin
            corr.magnitude = {s1_carry, s1_sum};
            corr.sign      = s1_sign_a;
        end else if (!s1_a_lt_b) begin
            corr.magnitude = {1'b0, s1_sum};
            corr.sign      = s1_sign_a;
        end else begin
            corr.magnitude = {1'b0, neg_sum};
            corr.sign      = ~s1_sign_a;
        end
        corr.is_zero = (corr.magnitude == '0);
        if (corr.is_zero) begin
            corr.sign = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
        end else if (in_xfer) begin
            s1_valid <= 1'b1;
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (in_xfer) begin
            s1_eff_sub <= bus.eff_sub;
            s1_a_lt_b  <= bus.a_lt_b;
            s1_carry   <= bus.carry;
            s1_sign_a  <= bus.sign_a;
            s1_sum     <= bus.sum;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid       <= 1'b0;
            s2_res         <= '0;
            s2_res.is_zero <= 1'b1;
        end else if (s2_load) begin
            s2_valid <= 1'b1;
            s2_res   <= corr;
        end else if (out_xfer) begin
            s2_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || cnt_clr) begin
            ovf_count <= '0;
        end else if (out_xfer && s2_res.magnitude[WIDTH] && ovf_count != '1) begin
            ovf_count <= ovf_count + CNT_W'(1);
        end
    end

    assign bus.out_valid = s2_valid;
    assign bus.sign      = s2_res.sign;
    assign bus.magnitude = s2_res.magnitude;
    assign bus.is_zero   = s2_res.is_zero;
endmodule

// File: tb/tb_result_corrector.sv
// Directed and randomized checks of result_corrector against a queue-based arithmetic model.
module tb_result_corrector;
    import calc_pkg::*;

    localparam int W  = 8;
    localparam int CW = 2;
    localparam int CNT_MAX = (1 << CW) - 1;

    typedef struct {
        logic s;
        int   m;
        logic z;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cnt_clr = 1'b0;
    logic [CW-1:0] ovf_count;

    always #5 clk = ~clk;

    result_corrector_if #(.WIDTH(W)) bus ();

    result_corrector #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .cnt_clr   (cnt_clr),
        .ovf_count (ovf_count)
    );

    int   tests = 0;
    int   failed = 0;
    int   cnt_m = 0;
    bit   accepted = 1'b0;
    bit   held = 1'b0;
    exp_t q[$];

    function automatic exp_t ref_model(bit es, bit lt, bit c, bit sa, int s);
        exp_t r;
        int   m;
        bit   sg;
        if (!es) begin
            m  = c * (1 << W) + s;
            sg = sa;
        end else if (!lt) begin
            m  = s;
            sg = sa;
        end else begin
            m  = ((1 << W) - s) % (1 << W);
            sg = !sa;
        end
        if (m == 0) sg = 1'b0;
        r.s = sg;
        r.m = m;
        r.z = (m == 0);
        return r;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Samples the handshake just before the rising edge, updates the model, then advances one cycle.
    task automatic tick();
        exp_t e;
        bit   in_x;
        bit   out_x;
        #1;
        in_x  = rst_n && bus.in_valid && bus.in_ready;
        out_x = rst_n && bus.out_valid && bus.out_ready;
        chk("ovf_count", ovf_count, cnt_m);
        if (held) chk("hold_valid", bus.out_valid, 1);
        if (!rst_n) begin
            q.delete();
            cnt_m = 0;
            held  = 1'b0;
        end else begin
            if (bus.out_valid && !bus.out_ready && q.size() > 0) begin
                chk("hold_sign", bus.sign, q[0].s);
                chk("hold_mag", bus.magnitude, q[0].m);
            end
            if (out_x) begin
                if (q.size() == 0) begin
                    chk("spurious_out", bus.out_valid, 0);
                end else begin
                    e = q.pop_front();
                    chk("sign", bus.sign, e.s);
                    chk("magnitude", bus.magnitude, e.m);
                    chk("is_zero", bus.is_zero, e.z);
                    if (e.m >= (1 << W) && cnt_m < CNT_MAX) cnt_m++;
                end
            end
            if (cnt_clr) cnt_m = 0;
            held = bus.out_valid && !bus.out_ready;
            if (in_x) q.push_back(ref_model(bus.eff_sub, bus.a_lt_b, bus.carry, bus.sign_a, int'(bus.sum)));
        end
        accepted = in_x;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(bit es, bit lt, bit c, bit sa, logic [W-1:0] s);
        int guard = 0;
        bus.eff_sub  = es;
        bus.a_lt_b   = lt;
        bus.carry    = c;
        bus.sign_a   = sa;
        bus.sum      = s;
        bus.in_valid = 1'b1;
        tick();
        while (!accepted && guard < 20) begin
            tick();
            guard++;
        end
        if (!accepted) chk("send_timeout", bus.in_ready, 1);
    endtask

    task automatic idle(int n);
        bus.in_valid = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        int cyc;
        int k;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.eff_sub   = OP_ADD;
        bus.a_lt_b    = 1'b0;
        bus.carry     = 1'b0;
        bus.sign_a    = 1'b0;
        bus.sum       = '0;
        @(negedge clk);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_sign", bus.sign, 0);
        chk("rst_mag", bus.magnitude, 0);
        chk("rst_is_zero", bus.is_zero, 1);
        chk("rst_ovf", ovf_count, 0);
        chk("rst_in_ready", bus.in_ready, 1);

        // Latency: out_valid two edges after the input transfer.
        send(OP_ADD, 0, 0, 0, 8'h08);
        bus.in_valid = 1'b0;
        #1;
        chk("lat1_valid", bus.out_valid, 0);
        tick();
        chk("lat2_valid", bus.out_valid, 1);
        chk("lat2_mag", bus.magnitude, 9'h008);
        chk("lat2_zero", bus.is_zero, 0);
        tick();

        send(OP_SUB, 1, 0, 0, 8'hFE);
        send(OP_SUB, 0, 0, 1, 8'h00);
        send(OP_ADD, 0, 1, 0, 8'h2C);
        idle(3);
        chk("ovf_first", ovf_count, 1);

        repeat (5) send(OP_ADD, 0, 1, 0, 8'h2C);
        idle(3);
        chk("ovf_sat", ovf_count, 3);

        bus.out_ready = 1'b0;
        send(OP_ADD, 0, 1, 1, 8'h80);
        idle(3);
        bus.out_ready = 1'b1;
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("clr_priority", ovf_count, 0);

        // Back-pressure: out_ready low for cycles 3..6 of a 6-result stream.
        cyc = 1;
        k = 0;
        while (k < 6 && cyc < 40) begin
            if (cyc == 1 || accepted) begin
                bus.eff_sub = 1'($urandom);
                bus.a_lt_b  = 1'($urandom);
                bus.carry   = 1'($urandom);
                bus.sign_a  = 1'($urandom);
                bus.sum     = W'($urandom);
            end
            bus.in_valid  = 1'b1;
            bus.out_ready = !(cyc >= 3 && cyc <= 6);
            #1;
            if (cyc == 4) chk("bp_in_ready", bus.in_ready, 0);
            tick();
            if (accepted) k++;
            cyc++;
        end
        bus.out_ready = 1'b1;
        idle(6);
        chk("bp_drained", q.size(), 0);

        // Reset with two results in flight.
        send(OP_ADD, 0, 1, 0, 8'h01);
        idle(3);
        bus.out_ready = 1'b0;
        send(OP_ADD, 0, 0, 0, 8'h11);
        send(OP_SUB, 1, 0, 0, 8'h22);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        chk("mid_rst_valid", bus.out_valid, 0);
        chk("mid_rst_ovf", ovf_count, 0);
        chk("mid_rst_in_ready", bus.in_ready, 1);
        idle(5);

        // Randomized traffic with random back-pressure and occasional counter clears.
        bus.in_valid = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (!bus.in_valid || accepted) begin
                bus.in_valid = ($urandom_range(3) != 0);
                bus.eff_sub  = 1'($urandom);
                bus.a_lt_b   = 1'($urandom);
                bus.carry    = 1'($urandom);
                bus.sign_a   = 1'($urandom);
                bus.sum      = ($urandom_range(7) == 0) ? '0 : W'($urandom);
            end
            bus.out_ready = ($urandom_range(2) != 0);
            cnt_clr       = ($urandom_range(49) == 0);
            tick();
        end
        cnt_clr = 1'b0;
        bus.out_ready = 1'b1;
        idle(10);
        chk("rand_drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
